seq_det_scheduler: RTL and testbench

Time-multiplexes a single overlapping "101" Moore detection engine across NCH independent serial bit channels. A round-robin arbiter grants one requesting channel per cycle. The granted channel's saved 2-bit detector context is advanced by its bit and written back. Per-channel detect flags, a registered detect event with channel id, and a saturating global hit counter are produced for the downstream status/interrupt logic.

---
 rtl/seq_det_pkg.sv | 14 +
 rtl/seq101_next.sv | 21 ++
 rtl/seq_det_scheduler.sv | 104 ++++++++++
 tb/tb_seq_det_scheduler.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared constants for the time-multiplexed "101" detector scheduler.
package seq_det_pkg;

    // Detector context encoding: S3 means "101" has just been seen.
    localparam logic [1:0] S0 = 2'd0;
    localparam logic [1:0] S1 = 2'd1;
    localparam logic [1:0] S2 = 2'd2;
    localparam logic [1:0] S3 = 2'd3;

    // Default build parameters.
    localparam int NCH_DEF  = 4;
    localparam int CNTW_DEF = 8;

endpackage

// File: rtl/seq101_next.sv
// Overlapping "101" Moore next-state function; one instance is shared by all channels.
module seq101_next
    import seq_det_pkg::*;
(
    input  logic [1:0] state_i,
    input  logic       x_i,
    output logic [1:0] next_o
);

    // Next context from the current context and the granted bit.
    always_comb begin
        next_o = S0;
        case (state_i)
            S0: next_o = x_i ? S1 : S0;
            S1: next_o = x_i ? S1 : S2;
            S2: next_o = x_i ? S3 : S0;
            S3: next_o = x_i ? S1 : S2;
        endcase
    end

endmodule

// File: rtl/seq_det_scheduler.sv
// Round-robin scheduler sharing one "101" detector across NCH serial channels.
module seq_det_scheduler
    import seq_det_pkg::*;
#(
    parameter int NCH  = NCH_DEF,
    parameter int CNTW = CNTW_DEF,
    localparam int CHW = $clog2(NCH)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [NCH-1:0]  req_i,
    input  logic [NCH-1:0]  x_i,
    input  logic [NCH-1:0]  clr_i,
    output logic [NCH-1:0]  gnt_o,
    output logic [NCH-1:0]  z_o,
    output logic            det_valid_o,
    output logic [CHW-1:0]  det_ch_o,
    output logic [CNTW-1:0] hit_cnt_o
);

    localparam logic [CNTW-1:0] CNT_MAX = '1;
    localparam logic [CHW-1:0]  LAST_CH = CHW'(NCH - 1);

    logic [NCH-1:0][1:0] ctx_q, ctx_d;
    logic [NCH-1:0]      z_q, z_d;
    logic [CHW-1:0]      ptr_q;
    logic                det_valid_q;
    logic [CHW-1:0]      det_ch_q;
    logic [CNTW-1:0]     hit_cnt_q;

    logic [NCH-1:0]      mask;
    logic [NCH-1:0]      gnt;
    logic                gnt_any;
    logic [CHW-1:0]      gnt_idx;
    logic [1:0]          nxt;
    logic                hit;

    // Cleared channels are never eligible; nothing is granted while reset is held.
    assign mask = req_i & ~clr_i & {NCH{rst_ni}};

    // Round-robin search starting at ptr_q, wrapping modulo NCH.
    always_comb begin
        int unsigned idx;
        gnt_any = 1'b0;
        gnt_idx = '0;
        gnt     = '0;
        idx     = 0;
        for (int k = 0; k < NCH; k++) begin
            idx = (int'(ptr_q) + k) % NCH;
            if (!gnt_any && mask[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = CHW'(idx);
            end
        end
        if (gnt_any)
            gnt[gnt_idx] = 1'b1;
    end

    assign gnt_o = gnt;

    // The single shared detector engine advances only the granted context.
    seq101_next u_next (
        .state_i (ctx_q[gnt_idx]),
        .x_i     (x_i[gnt_idx]),
        .next_o  (nxt)
    );

    assign hit = gnt_any && (nxt == S3);

    // Per-channel next context: clear wins, else the granted one advances, others hold.
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        assign ctx_d[i] = clr_i[i] ? S0 : (gnt[i] ? nxt : ctx_q[i]);
        assign z_d[i]   = (ctx_d[i] == S3);
    end

    // Context, pointer, detect event and saturating hit counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ctx_q       <= '0;
            z_q         <= '0;
            ptr_q       <= '0;
            det_valid_q <= 1'b0;
            det_ch_q    <= '0;
            hit_cnt_q   <= '0;
        end else begin
            ctx_q       <= ctx_d;
            z_q         <= z_d;
            det_valid_q <= hit;
            if (gnt_any)
                ptr_q <= (gnt_idx == LAST_CH) ? '0 : gnt_idx + 1'b1;
            if (hit) begin
                det_ch_q <= gnt_idx;
                if (hit_cnt_q != CNT_MAX)
                    hit_cnt_q <= hit_cnt_q + 1'b1;
            end
        end
    end

    assign z_o         = z_q;
    assign det_valid_o = det_valid_q;
    assign det_ch_o    = det_ch_q;
    assign hit_cnt_o   = hit_cnt_q;

endmodule

// File: tb/tb_seq_det_scheduler.sv
// Directed bench for seq_det_scheduler (NCH=4, CNTW=2 so saturation is reachable).
module tb_seq_det_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = '0;
    logic [3:0] x = '0;
    logic [3:0] clr = '0;
    logic [3:0] gnt;
    logic [3:0] z;
    logic       det_valid;
    logic [1:0] det_ch;
    logic [1:0] hit_cnt;

    int errors = 0;
    int checks = 0;

    seq_det_scheduler #(.NCH(4), .CNTW(2)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_i       (req),
        .x_i         (x),
        .clr_i       (clr),
        .gnt_o       (gnt),
        .z_o         (z),
        .det_valid_o (det_valid),
        .det_ch_o    (det_ch),
        .hit_cnt_o   (hit_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply inputs mid-cycle, check the combinational grant, then clock once.
    task automatic step(input logic [3:0] r, input logic [3:0] xx, input logic [3:0] c,
                        input logic [3:0] eg, input string tag);
        req = r; x = xx; clr = c;
        #1;
        chk({tag, ".gnt"}, 32'(gnt), 32'(eg));
        @(posedge clk);
        #1;
    endtask

    task automatic outs(input string tag, input logic [3:0] ez, input logic edv,
                        input logic [1:0] ech, input logic [1:0] ecnt);
        chk({tag, ".z"}, 32'(z), 32'(ez));
        chk({tag, ".det_valid"}, 32'(det_valid), 32'(edv));
        chk({tag, ".det_ch"}, 32'(det_ch), 32'(ech));
        chk({tag, ".hit_cnt"}, 32'(hit_cnt), 32'(ecnt));
    endtask

    task automatic do_reset();
        req = '0; x = '0; clr = '0;
        rst_n = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [14:0] sbits;
        int          ndet;
        // ---------------- reset ----------------
        req = 4'b1111;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst.gnt", 32'(gnt), 32'h0);
        outs("rst", 4'b0000, 1'b0, 2'd0, 2'd0);
        rst_n = 1'b1;
        #1;
        chk("rel.gnt", 32'(gnt), 32'h1);

        // ---------------- single channel 1,0,1,0,1 ----------------
        do_reset();
        step(4'b0001, 4'b0001, 4'b0000, 4'b0001, "s1"); outs("s1", 4'b0000, 1'b0, 2'd0, 2'd0);
        step(4'b0001, 4'b0000, 4'b0000, 4'b0001, "s2"); outs("s2", 4'b0000, 1'b0, 2'd0, 2'd0);
        step(4'b0001, 4'b0001, 4'b0000, 4'b0001, "s3"); outs("s3", 4'b0001, 1'b1, 2'd0, 2'd1);
        step(4'b0001, 4'b0000, 4'b0000, 4'b0001, "s4"); outs("s4", 4'b0000, 1'b0, 2'd0, 2'd1);
        step(4'b0001, 4'b0001, 4'b0000, 4'b0001, "s5"); outs("s5", 4'b0001, 1'b1, 2'd0, 2'd2);
        step(4'b0000, 4'b0000, 4'b0000, 4'b0000, "s6"); outs("s6", 4'b0001, 1'b0, 2'd0, 2'd2);

        // ---------------- interleave ch0 1,0,1 / ch1 1,1,0 ----------------
        do_reset();
        step(4'b0011, 4'b0011, 4'b0000, 4'b0001, "i1"); outs("i1", 4'b0000, 1'b0, 2'd0, 2'd0);
        step(4'b0011, 4'b0010, 4'b0000, 4'b0010, "i2"); outs("i2", 4'b0000, 1'b0, 2'd0, 2'd0);
        step(4'b0011, 4'b0010, 4'b0000, 4'b0001, "i3"); outs("i3", 4'b0000, 1'b0, 2'd0, 2'd0);
        step(4'b0011, 4'b0011, 4'b0000, 4'b0010, "i4"); outs("i4", 4'b0000, 1'b0, 2'd0, 2'd0);
        step(4'b0011, 4'b0001, 4'b0000, 4'b0001, "i5"); outs("i5", 4'b0001, 1'b1, 2'd0, 2'd1);
        step(4'b0011, 4'b0000, 4'b0000, 4'b0010, "i6"); outs("i6", 4'b0001, 1'b0, 2'd0, 2'd1);
        // ch1 should sit in S2: a 1 completes "101" (ptr is 2, wraps to ch1)
        step(4'b0010, 4'b0010, 4'b0000, 4'b0010, "i7"); outs("i7", 4'b0011, 1'b1, 2'd1, 2'd2);

        // ---------------- clear on ch2 ----------------
        do_reset();
        step(4'b0100, 4'b0100, 4'b0000, 4'b0100, "c1");
        step(4'b0100, 4'b0000, 4'b0000, 4'b0100, "c2");
        step(4'b0100, 4'b0100, 4'b0100, 4'b0000, "c3"); outs("c3", 4'b0000, 1'b0, 2'd0, 2'd0);
        step(4'b0100, 4'b0100, 4'b0000, 4'b0100, "c4"); outs("c4", 4'b0000, 1'b0, 2'd0, 2'd0);
        // context S1: 0 then 1 detects
        step(4'b0100, 4'b0000, 4'b0000, 4'b0100, "c5"); outs("c5", 4'b0000, 1'b0, 2'd0, 2'd0);
        step(4'b0100, 4'b0100, 4'b0000, 4'b0100, "c6"); outs("c6", 4'b0100, 1'b1, 2'd2, 2'd1);
        // clr on an S3 channel drops z only
        step(4'b0000, 4'b0000, 4'b0100, 4'b0000, "c7"); outs("c7", 4'b0000, 1'b0, 2'd2, 2'd1);

        // ---------------- saturation: seven detections on ch3 ----------------
        do_reset();
        sbits = 15'b101010101010101;
        ndet = 0;
        for (int i = 0; i < 15; i++) begin
            logic exp_dv;
            exp_dv = (i >= 2) && sbits[i];
            if (exp_dv) ndet++;
            step(4'b1000, {sbits[i], 3'b000}, 4'b0000, 4'b1000, "sat");
            chk("sat.det_valid", 32'(det_valid), 32'(exp_dv));
            chk("sat.hit_cnt", 32'(hit_cnt), (ndet > 3) ? 32'd3 : 32'(ndet));
        end
        chk("sat.ndet", 32'(ndet), 32'd7);
        chk("sat.det_ch", 32'(det_ch), 32'd3);

        // ---------------- async reset mid-sequence ----------------
        do_reset();
        step(4'b0010, 4'b0010, 4'b0000, 4'b0010, "a1");
        step(4'b0010, 4'b0000, 4'b0000, 4'b0010, "a2");
        step(4'b0010, 4'b0010, 4'b0000, 4'b0010, "a3"); outs("a3", 4'b0010, 1'b1, 2'd1, 2'd1);
        step(4'b0010, 4'b0000, 4'b0000, 4'b0010, "a4"); outs("a4", 4'b0000, 1'b0, 2'd1, 2'd1);
        // ch1 now in S2; z still high from a3 drops, so leave one more bit pending
        step(4'b0001, 4'b0001, 4'b0000, 4'b0001, "a5");
        step(4'b0001, 4'b0000, 4'b0000, 4'b0001, "a6");
        step(4'b0001, 4'b0001, 4'b0000, 4'b0001, "a7"); outs("a7", 4'b0001, 1'b1, 2'd0, 2'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar.gnt", 32'(gnt), 32'h0);
        outs("ar", 4'b0000, 1'b0, 2'd0, 2'd0);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        step(4'b0010, 4'b0010, 4'b0000, 4'b0010, "a8"); outs("a8", 4'b0000, 1'b0, 2'd0, 2'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
